// File: rtl/drive_cmd_pkg.sv
// Shared definitions for the drive command arbiter: command bit positions,
// UART frame constants and the arbiter state encoding.
package drive_cmd_pkg;

  // Command bit positions inside one requester's 6-bit command
  localparam int CMD_FWD     = 0;
  localparam int CMD_BACK    = 1;
  localparam int CMD_LEFT    = 2;
  localparam int CMD_RIGHT   = 3;
  localparam int CMD_PLACE   = 4;
  localparam int CMD_DESTROY = 5;

  // Every frame sent to the car carries this header in bits [7:6]
  localparam logic [1:0] FRAME_HDR  = 2'b10;
  // Header with all command bits clear: the car stops
  localparam logic [7:0] FRAME_STOP = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/drive_cmd_arbiter_pick.sv
// Combinational winner select for the drive command arbiter.
// Default: fixed priority, lowest index wins.
// With DRIVE_CMD_ARB_RR_EN defined: round-robin starting at last_owner+1.
module drive_cmd_pick
  import drive_cmd_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_owner,
  output logic                    valid,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IW = $clog2(NREQ);

`ifdef DRIVE_CMD_ARB_RR_EN
  // Scan from the requester after the previous owner, wrapping; first hit wins
  always_comb begin
    int idx;
    idx   = 0;
    valid = 1'b0;
    index = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_owner) + k) % NREQ;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        index = IW'(idx);
      end
    end
  end
`else
  // Fixed priority has no memory of the previous owner
  logic unused_last_owner;
  assign unused_last_owner = ^last_owner;

  // Scan from the top down so the lowest requesting index is left standing
  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        index = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/drive_cmd_arbiter.sv
// Drive command arbiter: shares the single UART command frame to the car
// between NREQ drive requesters, sanitises contradictory command bits and
// inserts a STOP gap on every ownership change.
// Build option: DRIVE_CMD_ARB_RR_EN selects round-robin arbitration with
// time-slice preemption instead of fixed priority.
module drive_cmd_arbiter
  import drive_cmd_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 2
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [NREQ-1:0]     req,
  input  logic [6*NREQ-1:0]   cmd,
  output logic [NREQ-1:0]     gnt,
  output logic [7:0]          frame,
  output logic                conflict,
  output logic                gap
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last_owner;
  logic [HW-1:0]   hold_cnt;
  logic [GW-1:0]   gap_cnt;

  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [5:0]      win_cmd;
  logic [5:0]      own_cmd;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] own_onehot;
  logic            own_req;
  logic            others_pend;
  logic            hold_done;
  logic            preempt;
`ifndef DRIVE_CMD_ARB_RR_EN
  logic [NREQ-1:0] higher_mask;
`endif

  // Clear both bits of any contradictory pair
  function automatic logic [5:0] sanitise(input logic [5:0] c);
    logic [5:0] s;
    s = c;
    if (c[CMD_FWD] && c[CMD_BACK]) begin
      s[CMD_FWD]  = 1'b0;
      s[CMD_BACK] = 1'b0;
    end
    if (c[CMD_LEFT] && c[CMD_RIGHT]) begin
      s[CMD_LEFT]  = 1'b0;
      s[CMD_RIGHT] = 1'b0;
    end
    if (c[CMD_PLACE] && c[CMD_DESTROY]) begin
      s[CMD_PLACE]   = 1'b0;
      s[CMD_DESTROY] = 1'b0;
    end
    return s;
  endfunction

  function automatic logic needs_sanitise(input logic [5:0] c);
    return (c[CMD_FWD] & c[CMD_BACK]) | (c[CMD_LEFT] & c[CMD_RIGHT]) |
           (c[CMD_PLACE] & c[CMD_DESTROY]);
  endfunction

  drive_cmd_pick #(
    .NREQ(NREQ)
  ) u_pick (
    .req       (req),
    .last_owner(last_owner),
    .valid     (win_vld),
    .index     (win_idx)
  );

  // Pull out the winner's and the owner's command slices and masks
  always_comb begin
    win_cmd    = '0;
    own_cmd    = '0;
    win_onehot = '0;
    own_onehot = '0;
`ifndef DRIVE_CMD_ARB_RR_EN
    higher_mask = '0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      if (IW'(i) == win_idx) begin
        win_cmd       = cmd[6*i +: 6];
        win_onehot[i] = 1'b1;
      end
      if (IW'(i) == owner) begin
        own_cmd       = cmd[6*i +: 6];
        own_onehot[i] = 1'b1;
      end
`ifndef DRIVE_CMD_ARB_RR_EN
      if (IW'(i) < owner) higher_mask[i] = 1'b1;
`endif
    end
  end

  assign own_req     = |(req & own_onehot);
  assign others_pend = |(req & ~own_onehot);
  // Looks one cycle ahead so the owner holds the grant for exactly HOLD_CYC
  // cycles; hold_cnt itself saturates at HOLD_CYC.
  assign hold_done   = (hold_cnt >= HW'(HOLD_CYC - 1));
`ifdef DRIVE_CMD_ARB_RR_EN
  assign preempt     = hold_done && others_pend;
`else
  assign preempt     = hold_done && |(req & higher_mask);
`endif

  // Arbiter FSM with registered grant, frame and status outputs
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IW'(NREQ - 1);
      hold_cnt   <= '0;
      gap_cnt    <= '0;
      gnt        <= '0;
      frame      <= FRAME_STOP;
      conflict   <= 1'b0;
      gap        <= 1'b0;
    end else if (!enable) begin
      state    <= IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      gnt      <= '0;
      frame    <= FRAME_STOP;
      conflict <= 1'b0;
      gap      <= 1'b0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (state == GAP && gap_cnt != GW'(GAP_CYC - 1)) begin
            gap_cnt <= gap_cnt + 1'b1;
          end else if (win_vld) begin
            state      <= OWN;
            owner      <= win_idx;
            last_owner <= win_idx;
            hold_cnt   <= '0;
            gap_cnt    <= '0;
            gnt        <= win_onehot;
            frame      <= {FRAME_HDR, sanitise(win_cmd)};
            conflict   <= needs_sanitise(win_cmd);
            gap        <= 1'b0;
          end else begin
            state    <= IDLE;
            gap_cnt  <= '0;
            gnt      <= '0;
            frame    <= FRAME_STOP;
            conflict <= 1'b0;
            gap      <= 1'b0;
          end
        end
        OWN: begin
          if ((!own_req && others_pend) || (own_req && preempt)) begin
            state    <= GAP;
            gap_cnt  <= '0;
            gnt      <= '0;
            frame    <= FRAME_STOP;
            conflict <= 1'b0;
            gap      <= 1'b1;
          end else if (!own_req) begin
            state    <= IDLE;
            gnt      <= '0;
            frame    <= FRAME_STOP;
            conflict <= 1'b0;
          end else begin
            if (hold_cnt != HW'(HOLD_CYC)) hold_cnt <= hold_cnt + 1'b1;
            frame    <= {FRAME_HDR, sanitise(own_cmd)};
            conflict <= needs_sanitise(own_cmd);
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= '0;
          frame    <= FRAME_STOP;
          conflict <= 1'b0;
          gap      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Scoreboard bench for drive_cmd_arbiter (NREQ=3, HOLD_CYC=4, GAP_CYC=2).
// The driver pushes the outputs expected after each clock edge; the monitor
// pops and compares on every falling edge.
module tb_drive_cmd_arbiter;

  typedef struct {
    logic [2:0] g;
    logic [7:0] f;
    logic       c;
    logic       gp;
    string      nm;
  } exp_t;

  logic        sys_clk = 1'b0;
  logic        rst     = 1'b0;
  logic        enable  = 1'b0;
  logic [2:0]  req     = '0;
  logic [17:0] cmd     = '0;
  logic [2:0]  gnt;
  logic [7:0]  frame;
  logic        conflict;
  logic        gap;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  drive_cmd_arbiter #(
    .NREQ(3), .HOLD_CYC(4), .GAP_CYC(2)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .enable  (enable),
    .req     (req),
    .cmd     (cmd),
    .gnt     (gnt),
    .frame   (frame),
    .conflict(conflict),
    .gap     (gap)
  );

  always #5 sys_clk = ~sys_clk;

  // Monitor: compare DUT outputs against the oldest expectation each cycle
  initial begin
    forever begin
      @(negedge sys_clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        checks++;
        if ({gnt, frame, conflict, gap} !== {mon_e.g, mon_e.f, mon_e.c, mon_e.gp}) begin
          errors++;
          $display("FAIL %s: got gnt=%b frame=%h conflict=%b gap=%b, want gnt=%b frame=%h conflict=%b gap=%b",
                   mon_e.nm, gnt, frame, conflict, gap, mon_e.g, mon_e.f, mon_e.c, mon_e.gp);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input logic rs, input logic en, input logic [2:0] rq,
                      input logic [17:0] c, input logic [2:0] eg,
                      input logic [7:0] ef, input logic ec, input logic egp,
                      input string nm);
    exp_t e;
    @(negedge sys_clk);
    #1;
    rst    = rs;
    enable = en;
    req    = rq;
    cmd    = c;
    e.g  = eg;
    e.f  = ef;
    e.c  = ec;
    e.gp = egp;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  localparam logic [5:0] C0 = 6'b000100;
  localparam logic [5:0] C1 = 6'b000001;

  initial begin
    logic [17:0] cv;
    cv = '0;
    step(0, 0, 3'b000, 18'd0, 3'b000, 8'h80, 0, 0, "reset_0");
    step(0, 0, 3'b000, 18'd0, 3'b000, 8'h80, 0, 0, "reset_1");
`ifdef DRIVE_CMD_ARB_RR_EN
    cv = {6'b000100, 6'b000010, 6'b000001};
    for (int r = 0; r < 4; r++) begin
      logic [2:0] oh;
      logic [7:0] fr;
      oh = 3'b001 << (r % 3);
      fr = {2'b10, cv[6*(r%3) +: 6]};
      for (int k = 0; k < 4; k++) step(1, 1, 3'b111, cv, oh, fr, 0, 0, "rr_own");
      for (int k = 0; k < 2; k++) step(1, 1, 3'b111, cv, 3'b000, 8'h80, 0, 1, "rr_gap");
    end
`else
    cv = {6'b000000, C1, C0};
    // Single requester granted one cycle after it is sampled
    step(1, 1, 3'b010, cv, 3'b010, 8'h81, 0, 0, "t1_grant");
    // Higher-priority request must wait for the hold time
    step(1, 1, 3'b010, cv, 3'b010, 8'h81, 0, 0, "t2_hold_a");
    step(1, 1, 3'b010, cv, 3'b010, 8'h81, 0, 0, "t2_hold_b");
    step(1, 1, 3'b011, cv, 3'b010, 8'h81, 0, 0, "t2_no_preempt");
    step(1, 1, 3'b011, cv, 3'b000, 8'h80, 0, 1, "t2_gap_1");
    step(1, 1, 3'b011, cv, 3'b000, 8'h80, 0, 1, "t2_gap_2");
    step(1, 1, 3'b011, cv, 3'b001, 8'h84, 0, 0, "t2_owner0");
    // Lower-priority request never preempts
    for (int k = 0; k < 6; k++)
      step(1, 1, 3'b101, cv, 3'b001, 8'h84, 0, 0, "t3_low_no_preempt");
    cv = {6'b010000, C1, C0};
    step(1, 1, 3'b100, cv, 3'b000, 8'h80, 0, 1, "t3_gap_1");
    step(1, 1, 3'b100, cv, 3'b000, 8'h80, 0, 1, "t3_gap_2");
    step(1, 1, 3'b100, cv, 3'b100, 8'h90, 0, 0, "t3_owner2");
    // Sanitising of contradictory pairs
    step(1, 1, 3'b100, {6'b000011, C1, C0}, 3'b100, 8'h80, 1, 0, "t4_fwd_back");
    step(1, 1, 3'b100, {6'b001101, C1, C0}, 3'b100, 8'h81, 1, 0, "t4_left_right");
    step(1, 1, 3'b100, {6'b110000, C1, C0}, 3'b100, 8'h80, 1, 0, "t4_place_destroy");
    step(1, 1, 3'b100, {6'b100000, C1, C0}, 3'b100, 8'hA0, 0, 0, "t4_clean");
    // Disable in the middle of a gap
    cv = {6'b100000, C1, C0};
    step(1, 1, 3'b101, cv, 3'b000, 8'h80, 0, 1, "t5_gap_1");
    step(1, 0, 3'b101, cv, 3'b000, 8'h80, 0, 0, "t5_disable");
    step(1, 1, 3'b101, cv, 3'b001, 8'h84, 0, 0, "t5_regrant");
    // Asynchronous reset while owning, checked before any clock edge
    @(negedge sys_clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({gnt, frame, conflict, gap} !== {3'b000, 8'h80, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL t5_async_rst: got gnt=%b frame=%h conflict=%b gap=%b, want gnt=000 frame=80 conflict=0 gap=0",
               gnt, frame, conflict, gap);
    end
    step(0, 1, 3'b101, cv, 3'b000, 8'h80, 0, 0, "t5_in_reset");
    step(1, 1, 3'b000, cv, 3'b000, 8'h80, 0, 0, "t5_idle");
    // Owner drop together with a higher-priority request is a drop; a
    // request withdrawn during the gap is not granted
    step(1, 1, 3'b010, cv, 3'b010, 8'h81, 0, 0, "t6_grant1");
    step(1, 1, 3'b001, cv, 3'b000, 8'h80, 0, 1, "t6_drop_gap");
    step(1, 1, 3'b000, cv, 3'b000, 8'h80, 0, 1, "t6_gap_2");
    step(1, 1, 3'b000, cv, 3'b000, 8'h80, 0, 0, "t6_withdrawn");
`endif
    @(negedge sys_clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
